// File: rtl/fetch_stage.sv
// F stage of the 5-stage MIPS pipeline: PC register, next-PC select, fetch counter.
// Define FETCH_EXC_EN to add the F_exc_adel fetch-address check.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] IM_BASE  = 32'h0000_3000,
   parameter logic [31:0] IM_END   = 32'h0000_6FFC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [2:0]  npc_op,
   input  logic [31:0] D_PC,
   input  logic [15:0] D_imm16,
   input  logic [25:0] D_imm26,
   input  logic [31:0] D_rs_data,
   input  logic [31:0] i_inst_rdata,
   output logic [31:0] i_inst_addr,
   output logic [31:0] F_PC,
   output logic [31:0] F_PCplus8,
   output logic [31:0] F_instr,
   output logic [31:0] fetch_cnt
`ifdef FETCH_EXC_EN
   ,
   output logic        F_exc_adel
`endif
);

   logic [31:0] pc_q;
   logic [31:0] cnt_q;
   logic [31:0] npc;
   logic [31:0] seq_pc;
   logic [31:0] br_pc;
   logic [31:0] j_pc;

   assign seq_pc = pc_q + 32'd4;
   assign br_pc  = D_PC + 32'd4 + {{14{D_imm16[15]}}, D_imm16, 2'b00};
   assign j_pc   = {D_PC[31:28], D_imm26, 2'b00};

   always_comb begin
      npc = seq_pc;
      case (npc_op)
         3'd1:    npc = br_pc;
         3'd2:    npc = j_pc;
         3'd3:    npc = D_rs_data;
         default: npc = seq_pc;
      endcase
   end

   // D is frozen by the same stall, so a held redirect is simply re-presented
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q  <= RESET_PC;
         cnt_q <= '0;
      end else if (!stall) begin
         pc_q  <= npc;
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign F_PC        = pc_q;
   assign i_inst_addr = pc_q;
   assign F_PCplus8   = pc_q + 32'd8;
   assign fetch_cnt   = cnt_q;

`ifdef FETCH_EXC_EN
   assign F_exc_adel = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) ||
                       (pc_q > IM_END);
   assign F_instr    = F_exc_adel ? 32'h0000_0000 : i_inst_rdata;
`else
   assign F_instr = i_inst_rdata;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, corner sequences and
// randomized traffic against a behavioural next-PC model.
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_3000;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [2:0]  npc_op;
   logic [31:0] D_PC;
   logic [15:0] D_imm16;
   logic [25:0] D_imm26;
   logic [31:0] D_rs_data;
   logic [31:0] i_inst_rdata;
   logic [31:0] i_inst_addr;
   logic [31:0] F_PC;
   logic [31:0] F_PCplus8;
   logic [31:0] F_instr;
   logic [31:0] fetch_cnt;
`ifdef FETCH_EXC_EN
   logic        F_exc_adel;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
   endfunction

   assign i_inst_rdata = mem(i_inst_addr);

   fetch_stage dut (
      .clk(clk),
      .reset(reset),
      .stall(stall),
      .npc_op(npc_op),
      .D_PC(D_PC),
      .D_imm16(D_imm16),
      .D_imm26(D_imm26),
      .D_rs_data(D_rs_data),
      .i_inst_rdata(i_inst_rdata),
      .i_inst_addr(i_inst_addr),
      .F_PC(F_PC),
      .F_PCplus8(F_PCplus8),
      .F_instr(F_instr),
      .fetch_cnt(fetch_cnt)
`ifdef FETCH_EXC_EN
      ,
      .F_exc_adel(F_exc_adel)
`endif
   );

   typedef struct {
      logic        rst;
      logic        stl;
      logic [2:0]  op;
      logic [31:0] dpc;
      logic [15:0] i16;
      logic [25:0] i26;
      logic [31:0] rs;
      logic [31:0] epc;
      logic [31:0] ecnt;
   } vec_t;

   function automatic vec_t mk(input logic rst, input logic stl,
                               input logic [2:0] op, input logic [31:0] dpc,
                               input logic [15:0] i16, input logic [25:0] i26,
                               input logic [31:0] rs, input logic [31:0] epc,
                               input logic [31:0] ecnt);
      vec_t v;
      v.rst = rst; v.stl = stl; v.op = op; v.dpc = dpc;
      v.i16 = i16; v.i26 = i26; v.rs = rs;
      v.epc = epc; v.ecnt = ecnt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic bad_addr(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6FFC);
   endfunction

   task automatic check_all(input string tag, input logic [31:0] epc,
                            input logic [31:0] ecnt);
      logic [31:0] einstr;
      einstr = mem(epc);
`ifdef FETCH_EXC_EN
      if (bad_addr(epc)) einstr = 32'h0;
      chk({tag, ".adel"}, {31'd0, F_exc_adel}, {31'd0, bad_addr(epc)});
`endif
      chk({tag, ".pc"}, F_PC, epc);
      chk({tag, ".addr"}, i_inst_addr, epc);
      chk({tag, ".pc8"}, F_PCplus8, epc + 32'd8);
      chk({tag, ".cnt"}, fetch_cnt, ecnt);
      chk({tag, ".instr"}, F_instr, einstr);
   endtask

   task automatic drive(input logic rst, input logic stl, input logic [2:0] op,
                        input logic [31:0] dpc, input logic [15:0] i16,
                        input logic [25:0] i26, input logic [31:0] rs);
      reset = rst; stall = stl; npc_op = op; D_PC = dpc;
      D_imm16 = i16; D_imm26 = i26; D_rs_data = rs;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[17];
   logic [31:0] m_pc;
   logic [31:0] m_cnt;

   initial begin
      drive(1'b1, 1'b0, 3'd0, '0, '0, '0, '0);

      tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h3000, 0);
      tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h3004, 1);
      tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h3008, 2);
      tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h300C, 3);
      tbl[4]  = mk(0, 0, 1, 32'h3010, 16'hFFFC, 0, 0, 32'h3004, 4);
      tbl[5]  = mk(0, 0, 1, 32'h3010, 16'h0003, 0, 0, 32'h3020, 5);
      tbl[6]  = mk(0, 0, 2, 32'h3000, 0, 26'h0000C10, 0, 32'h3040, 6);
      tbl[7]  = mk(0, 0, 3, 0, 0, 0, 32'h3100, 32'h3100, 7);
      tbl[8]  = mk(0, 1, 1, 32'h3010, 16'h0003, 0, 0, 32'h3100, 7);
      tbl[9]  = mk(0, 1, 1, 32'h3010, 16'h0003, 0, 0, 32'h3100, 7);
      tbl[10] = mk(0, 0, 1, 32'h3010, 16'h0003, 0, 0, 32'h3020, 8);
      tbl[11] = mk(1, 1, 3, 0, 0, 0, 32'h1234, 32'h3000, 0);
      tbl[12] = mk(0, 0, 3, 0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1);
      tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 2);
      tbl[14] = mk(0, 0, 5, 32'h3010, 16'h0003, 0, 32'h3100, 32'h4, 3);
      tbl[15] = mk(0, 0, 7, 32'h3010, 16'h0003, 0, 32'h3100, 32'h8, 4);
      tbl[16] = mk(0, 0, 2, 32'hF000_1234, 0, 26'h3FF_FFFF, 0,
                   32'hFFFF_FFFC, 5);

      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].rst, tbl[i].stl, tbl[i].op, tbl[i].dpc,
               tbl[i].i16, tbl[i].i26, tbl[i].rs);
         step();
         check_all($sformatf("vec%0d", i), tbl[i].epc, tbl[i].ecnt);
      end

`ifdef FETCH_EXC_EN
      drive(1'b1, 1'b0, 3'd0, '0, '0, '0, '0);
      step();
      drive(1'b0, 1'b0, 3'd3, '0, '0, '0, 32'h3002);
      step();
      check_all("exc_unaligned", 32'h3002, 1);
      drive(1'b0, 1'b0, 3'd3, '0, '0, '0, 32'h7000);
      step();
      check_all("exc_high", 32'h7000, 2);
      drive(1'b0, 1'b0, 3'd3, '0, '0, '0, 32'h6FFC);
      step();
      check_all("exc_top_ok", 32'h6FFC, 3);
      drive(1'b0, 1'b0, 3'd3, '0, '0, '0, 32'h2FFC);
      step();
      check_all("exc_low", 32'h2FFC, 4);
`endif

      drive(1'b1, 1'b0, 3'd0, '0, '0, '0, '0);
      step();
      m_pc  = RST_PC;
      m_cnt = 0;
      check_all("rnd_reset", m_pc, m_cnt);

      for (int k = 0; k < 3000; k++) begin
         logic        r;
         logic        s;
         logic [2:0]  op;
         logic [31:0] dpc;
         logic [15:0] i16;
         logic [25:0] i26;
         logic [31:0] rs;
         int          off;
         r   = ($urandom_range(0, 60) == 0);
         s   = ($urandom_range(0, 3) == 0);
         op  = 3'($urandom_range(0, 7));
         dpc = 32'h3000 + ($urandom_range(0, 4095) * 4);
         if ($urandom_range(0, 7) == 0) dpc = $urandom;
         i16 = 16'($urandom);
         i26 = 26'($urandom);
         rs  = ($urandom_range(0, 3) == 0) ? $urandom
                                           : 32'h3000 + ($urandom_range(0, 5000) * 4);
         drive(r, s, op, dpc, i16, i26, rs);
         step();
         if (r) begin
            m_pc  = RST_PC;
            m_cnt = 0;
         end else if (!s) begin
            m_cnt = m_cnt + 1;
            off   = int'($signed(i16)) * 4;
            if (op == 3'd1)      m_pc = dpc + 32'd4 + 32'(off);
            else if (op == 3'd2) m_pc = (dpc & 32'hF000_0000) + 32'(i26) * 32'd4;
            else if (op == 3'd3) m_pc = rs;
            else                 m_pc = m_pc + 32'd4;
         end
         check_all($sformatf("rnd%0d", k), m_pc, m_cnt);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
